// File: rtl/conv_window_buffer_if.sv
// Pixel-in / window-out stream bundle for the convolver front end.
// Slave is the window buffer; master is the pixel source plus the window consumer.
interface conv_window_buffer_if #(
  parameter int KERNEL_SIZE = 5,
  parameter int DATA_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0]                         pixel_in;
  logic                                          in_valid;
  logic                                          in_ready;
  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_out;
  logic                                          window_valid;
  logic                                          out_ready;
  logic                                          last_window;

  modport master (
    output pixel_in, in_valid, out_ready,
    input  in_ready, window_out, window_valid, last_window
  );

  modport slave (
    input  pixel_in, in_valid, out_ready,
    output in_ready, window_out, window_valid, last_window
  );
endinterface

// File: rtl/conv_window_buffer.sv
// Raster-order pixel stream to KxK sliding windows; window is registered 1 cycle after its newest pixel.
// A held window stalls the input (in_ready low) until downstream takes it.
module conv_window_buffer #(
  parameter int KERNEL_SIZE  = 5,
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28
) (
  input logic              clk,
  input logic              reset,
  conv_window_buffer_if.slave bus
);
  localparam int K  = KERNEL_SIZE;
  localparam int NE = K * K;
  localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  logic [CW-1:0]                 r_col;
  logic [RW-1:0]                 r_row;
  logic [NE-1:0][DATA_WIDTH-1:0] r_win;
  logic                          r_window_valid;
  logic                          r_last_window;
  logic [DATA_WIDTH-1:0]         r_lb [K-1][IMAGE_WIDTH];

  logic                         w_in_ready;
  logic                         w_accept;
  logic                         w_col_last;
  logic                         w_row_last;
  logic                         w_emit;
  logic [K-1:0][DATA_WIDTH-1:0] w_col_new;

  assign w_in_ready = !r_window_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_col_last = (r_col == CW'(IMAGE_WIDTH - 1));
  assign w_row_last = (r_row == RW'(IMAGE_HEIGHT - 1));
  // Column gating alone keeps stale columns from a previous row out of any emitted window.
  assign w_emit     = (r_row >= RW'(K - 1)) && (r_col >= CW'(K - 1));

  // Column entering the window: K-1 older rows from the line buffers, newest pixel at the bottom.
  always_comb begin
    w_col_new = '0;
    for (int r = 0; r < K - 1; r++) begin
      w_col_new[r] = r_lb[r][r_col];
    end
    w_col_new[K-1] = bus.pixel_in;
  end

  always_ff @(posedge clk) begin
    if (!reset && w_accept) begin
      for (int r = 0; r < K - 2; r++) begin
        r_lb[r][r_col] <= r_lb[r+1][r_col];
      end
      r_lb[K-2][r_col] <= bus.pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col          <= '0;
      r_row          <= '0;
      r_win          <= '0;
      r_window_valid <= 1'b0;
      r_last_window  <= 1'b0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          r_win[r*K+c] <= r_win[r*K+c+1];
        end
        r_win[r*K+K-1] <= w_col_new[r];
      end
      r_window_valid <= w_emit;
      r_last_window  <= w_emit && w_row_last && w_col_last;
    end else if (bus.out_ready) begin
      r_window_valid <= 1'b0;
      r_last_window  <= 1'b0;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.window_out   = r_win;
  assign bus.window_valid = r_window_valid;
  assign bus.last_window  = r_last_window;
endmodule
